// File: rtl/norm_pkg.sv
// Shared widths, FSM state encoding and flag layout for the sequential
// post-add normaliser.
package norm_pkg;

  localparam int unsigned MANT_W = 50;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;
  // Bit index into the mantissa and widened exponent (holds up to 257)
  localparam int unsigned POS_W  = 6;
  localparam int unsigned EXPX_W = EXP_W + 1;
  // Shifted mantissa bits kept for rounding: fraction plus round bit
  localparam int unsigned RND_W  = FRAC_W + 1;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT,
    ROUND,
    DONE
  } state_e;

  typedef struct packed {
    logic overflow;
    logic denormal;
    logic zero;
  } flags_t;

  // Width of a bit index inside a slice of the given width
  function automatic int unsigned idx_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/norm_seq_ctrl_lod_chunk.sv
// Combinational leading-one detector over one scan slice; reports whether the
// slice is nonzero and the index of its highest set bit.
module lod_chunk
  import norm_pkg::*;
#(
  parameter int unsigned CHUNK_W = 10
) (
  input  logic [CHUNK_W-1:0]          slice_i,
  output logic                        nonzero_c_o,
  output logic [idx_w(CHUNK_W)-1:0]   idx_c_o
);

  localparam int unsigned IDX_W = idx_w(CHUNK_W);

  assign nonzero_c_o = |slice_i;

  // Ascending walk so the highest set bit wins
  always_comb begin
    idx_c_o = '0;
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      if (slice_i[i]) begin
        idx_c_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/norm_seq_ctrl.sv
// Multi-cycle normaliser: scans the unnormalised sum for its leading one a
// slice at a time, shifts, rounds and packs a single-precision result.
module norm_seq_ctrl
  import norm_pkg::*;
#(
  parameter int unsigned CHUNK_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [2:0]        out_flags
);

  localparam int unsigned IDX_W     = idx_w(CHUNK_W);
  localparam int unsigned FIRST_LSB = MANT_W - CHUNK_W;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_max_q, exp_max_d;
  logic [POS_W-1:0]    slice_lsb_q, slice_lsb_d;
  logic [POS_W-1:0]    lead_pos_q, lead_pos_d;
  logic [RND_W-1:0]    shifted_q, shifted_d;
  logic [EXPX_W-1:0]   exp_q, exp_d;
  logic [RES_W-1:0]    result_q, result_d;
  flags_t              flags_q, flags_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [CHUNK_W-1:0]  slice_c;
  logic                slice_nz_c;
  logic [IDX_W-1:0]    slice_idx_c;

  logic [6:0]          norm_c;
  logic [EXPX_W-1:0]   e_plus2_c;
  logic                denorm_c;
  logic [EXPX_W-1:0]   shamt_c;
  logic [EXPX_W-1:0]   exp_norm_c;
  logic [RND_W-1:0]    shifted_c;
  logic [RES_W-1:0]    sum_c;
  logic [EXPX_W-1:0]   rexp_c;
  logic                ovf_c;

  // Single detector reused for every slice; slice_lsb_q walks MSB-first
  assign slice_c = mant_q[slice_lsb_q +: CHUNK_W];

  lod_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_lod (
    .slice_i     (slice_c),
    .nonzero_c_o (slice_nz_c),
    .idx_c_o     (slice_idx_c)
  );

  // Shift stage: clamp to exponent zero when the full shift would underflow
  assign norm_c     = 7'(MANT_W - 1) - 7'(lead_pos_q);
  assign e_plus2_c  = EXPX_W'(exp_max_q) + EXPX_W'(2);
  assign denorm_c   = e_plus2_c < EXPX_W'(norm_c);
  assign shamt_c    = denorm_c ? (e_plus2_c + EXPX_W'(1))
                               : (EXPX_W'(norm_c) + EXPX_W'(1));
  assign exp_norm_c = denorm_c ? '0 : (e_plus2_c - EXPX_W'(norm_c));
  assign shifted_c  = RND_W'((mant_q << shamt_c) >> (MANT_W - RND_W));

  // Round stage: a fraction carry ripples straight into the exponent
  assign sum_c  = {exp_q, shifted_q[RND_W-1:1]} + RES_W'(shifted_q[0]);
  assign rexp_c = sum_c[RES_W-1:FRAC_W];
  assign ovf_c  = rexp_c >= EXPX_W'(EXP_INF);

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mant_d      = mant_q;
    exp_max_d   = exp_max_q;
    slice_lsb_d = slice_lsb_q;
    lead_pos_d  = lead_pos_q;
    shifted_d   = shifted_q;
    exp_d       = exp_q;
    result_d    = result_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d      = in_sign;
          mant_d      = in_mant;
          exp_max_d   = in_exp_max;
          slice_lsb_d = POS_W'(FIRST_LSB);
          flags_d     = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (slice_nz_c) begin
          lead_pos_d = slice_lsb_q + POS_W'(slice_idx_c);
          state_d    = SHIFT;
        end else if (slice_lsb_q == '0) begin
          result_d              = '0;
          result_d[RES_W-1]     = sign_q;
          flags_d.zero          = 1'b1;
          state_d               = DONE;
        end else begin
          slice_lsb_d = slice_lsb_q - POS_W'(CHUNK_W);
        end
      end
      SHIFT: begin
        shifted_d        = shifted_c;
        exp_d            = exp_norm_c;
        flags_d.denormal = denorm_c;
        state_d          = ROUND;
      end
      ROUND: begin
        if (ovf_c) begin
          result_d         = {sign_q, EXP_INF, FRAC_W'(0)};
          flags_d.overflow = 1'b1;
        end else begin
          result_d = {sign_q, rexp_c[EXP_W-1:0], sum_c[FRAC_W-1:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mant_q      <= '0;
      exp_max_q   <= '0;
      slice_lsb_q <= '0;
      lead_pos_q  <= '0;
      shifted_q   <= '0;
      exp_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mant_q      <= mant_d;
      exp_max_q   <= exp_max_d;
      slice_lsb_q <= slice_lsb_d;
      lead_pos_q  <= lead_pos_d;
      shifted_q   <= shifted_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Self-checking bench for norm_seq_ctrl: directed vectors, randomized operands
// against a behavioural model, backpressure, reset abort and streaming traffic.
module tb_norm_seq_ctrl;

  localparam int CW = 10;
  localparam int NSLICE = 50 / CW;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [49:0] in_mant;
  logic [7:0]  in_exp_max;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  norm_seq_ctrl #(.CHUNK_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_mant    (in_mant),
    .in_exp_max (in_exp_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // Reference: find the leading one, apply the normalise/round rules with
  // integer arithmetic. lat = edges from accept edge until out_valid is seen.
  function automatic void model(input logic s, input logic [49:0] m,
                                input logic [7:0] e, output logic [31:0] r,
                                output logic [2:0] f, output int lat);
    int lp, norm, ex, tot, rex;
    logic [49:0] sh;
    bit den;
    lp = -1;
    for (int i = 49; i >= 0; i--) if (m[i] && lp < 0) lp = i;
    if (lp < 0) begin
      r = {s, 31'b0};
      f = 3'b001;
      lat = NSLICE;
      return;
    end
    norm = 49 - lp;
    den = 1'b0;
    if (int'(e) + 2 < norm) begin
      sh = m << (int'(e) + 3);
      ex = 0;
      den = 1'b1;
    end else begin
      sh = m << (norm + 1);
      ex = int'(e) + 2 - norm;
    end
    tot = ex * (1 << 23) + int'(sh[49:27]) + int'(sh[26]);
    rex = tot >> 23;
    if (rex >= 255) begin
      r = {s, 8'hFF, 23'h0};
      f = 3'b100;
    end else begin
      r = {s, rex[7:0], tot[22:0]};
      f = {1'b0, den, 1'b0};
    end
    lat = norm / CW + 3;
  endfunction

  function automatic logic [49:0] rand_mant();
    logic [49:0] m;
    m = 50'({$urandom, $urandom});
    return m >> $urandom_range(0, 50);
  endfunction

  function automatic logic [7:0] rand_exp();
    case ($urandom_range(0, 6))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd127;
      3: return 8'd253;
      4: return 8'd254;
      5: return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  // Accept one operand and wait for out_valid; leaves the result pending.
  task automatic run_op(input logic s, input logic [49:0] m, input logic [7:0] e,
                        output logic [31:0] r, output logic [2:0] f,
                        output int lat, output bit timeout);
    int n;
    timeout = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) timeout = 1'b1;
    in_valid = 1'b1; in_sign = s; in_mant = m; in_exp_max = e;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mant = rand_mant(); in_exp_max = 8'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (out_valid !== 1'b1) timeout = 1'b1;
    lat = n;
    r = out_result;
    f = out_flags;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_mant = '0; in_exp_max = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_result !== 32'h0) begin
      failures++; $display("FAIL reset_result got=%h want=00000000", out_result);
    end
    checks++;
    if (out_flags !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", out_flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [49:0] mv [5];
    logic [7:0]  ev [5];
    logic        sv [5];
    logic [31:0] rv [5];
    logic [2:0]  fv [5];
    int          lv [5];
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    bit          to;
    mv[0] = 50'h1 << 49;       ev[0] = 8'd127; sv[0] = 1'b0;
    rv[0] = 32'h40800000;      fv[0] = 3'b000; lv[0] = 3;
    mv[1] = '0;                ev[1] = 8'd77;  sv[1] = 1'b1;
    rv[1] = 32'h80000000;      fv[1] = 3'b001; lv[1] = 5;
    mv[2] = 50'h1 << 45;       ev[2] = 8'd0;   sv[2] = 1'b0;
    rv[2] = 32'h00200000;      fv[2] = 3'b010; lv[2] = 3;
    mv[3] = {25'h1FFFFFF, 25'h0}; ev[3] = 8'd125; sv[3] = 1'b0;
    rv[3] = 32'h40000000;      fv[3] = 3'b000; lv[3] = 3;
    mv[4] = 50'h1 << 49;       ev[4] = 8'd254; sv[4] = 1'b0;
    rv[4] = 32'h7F800000;      fv[4] = 3'b100; lv[4] = 3;
    for (int i = 0; i < 5; i++) begin
      run_op(sv[i], mv[i], ev[i], r, f, lat, to);
      checks++;
      if (to || lat != lv[i]) begin
        failures++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, lv[i]);
      end
      checks++;
      if (r !== rv[i]) begin
        failures++; $display("FAIL directed%0d_result got=%h want=%h", i, r, rv[i]);
      end
      checks++;
      if (f !== fv[i]) begin
        failures++; $display("FAIL directed%0d_flags got=%b want=%b", i, f, fv[i]);
      end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL directed%0d_release got=%b%b want=01", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er;
    logic [2:0]  f, ef;
    int          lat, el;
    bit          to;
    logic        s;
    logic [49:0] m;
    logic [7:0]  e;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom); m = rand_mant(); e = rand_exp();
      model(s, m, e, er, ef, el);
      run_op(s, m, e, r, f, lat, to);
      checks++;
      if (to || lat != el || r !== er || f !== ef) begin
        failures++;
        $display("FAIL random%0d m=%h e=%0d got=%h/%b/%0d want=%h/%b/%0d",
                 i, m, e, r, f, lat, er, ef, el);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    bit          to;
    run_op(1'b0, 50'h1 << 49, 8'd127, r, f, lat, to);
    checks++;
    if (to) begin
      failures++; $display("FAIL bp_start got=timeout want=out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h40800000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b r=%h rdy=%b want=v1 r=40800000 rdy=0",
                 i, out_valid, out_result, in_ready);
      end
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1; in_sign = 1'b0; in_mant = 50'h1; in_exp_max = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_during got=v%b rdy=%b want=v0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midrst_no_result got=%0d valid cycles want=0", seen);
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] ra, rb;
    logic [2:0]  fa, fb;
    int          la, lb, n;
    model(1'b0, 50'h1 << 40, 8'd100, ra, fa, la);
    model(1'b1, 50'h1 << 10, 8'd50, rb, fb, lb);
    in_valid = 1'b1; in_sign = 1'b0; in_mant = 50'h1 << 40; in_exp_max = 8'd100;
    @(posedge clk); #1;
    in_sign = 1'b1; in_mant = 50'h1 << 10; in_exp_max = 8'd50;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_result !== ra || out_flags !== fa) begin
      failures++; $display("FAIL busy_first got=%h/%b want=%h/%b", out_result, out_flags, ra, fa);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    checks++;
    if (out_result !== rb || out_flags !== fb) begin
      failures++; $display("FAIL busy_second got=%h/%b want=%h/%b", out_result, out_flags, rb, fb);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] qr [$];
    logic [2:0]  qf [$];
    logic [31:0] er, cur_r;
    logic [2:0]  ef;
    int          el, n, delivered;
    bit          acc, dlv, held;
    delivered = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sign = 1'($urandom); in_mant = rand_mant(); in_exp_max = rand_exp();
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      held = out_valid && !out_ready;
      cur_r = out_result;
      if (acc) begin
        model(in_sign, in_mant, in_exp_max, er, ef, el);
        qr.push_back(er); qf.push_back(ef);
      end
      if (dlv) begin
        checks++;
        if (qr.size() == 0) begin
          failures++; $display("FAIL b2b_spurious got=%h want=no result", out_result);
        end else begin
          er = qr.pop_front(); ef = qf.pop_front();
          delivered++;
          if (out_result !== er || out_flags !== ef) begin
            failures++;
            $display("FAIL b2b_result got=%h/%b want=%h/%b", out_result, out_flags, er, ef);
          end
        end
      end
      @(posedge clk); #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== cur_r) begin
          failures++; $display("FAIL b2b_hold got=%h want=%h", out_result, cur_r);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (qr.size() > 0 && n < 100) begin
      if (out_valid === 1'b1) begin
        er = qr.pop_front(); ef = qf.pop_front();
        delivered++;
        checks++;
        if (out_result !== er || out_flags !== ef) begin
          failures++;
          $display("FAIL b2b_drain got=%h/%b want=%h/%b", out_result, out_flags, er, ef);
        end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    checks++;
    if (qr.size() != 0 || delivered < 20) begin
      failures++;
      $display("FAIL b2b_count got=%0d left=%0d want=0 left, >=20 delivered", delivered, qr.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
